read_channels_slv: RTL

Responder-side read channel block for the tiny AXI-style bus. It accepts read requests on the AR channel, queues them, fetches one 128-bit line per request from a local memory with fixed 1-cycle read latency, and returns the line as a 4-beat, 32-bit R burst tagged with the request ID. It sits on the slave side of the bus and terminates the reads issued by the master's read channel manager.

---
 rtl/read_channels_slv.sv | 136 +++++++++++++
 1 files changed

// File: rtl/read_channels_slv.sv
// Read-channel responder: queues AR requests, fetches one 128-bit line per request
// from a 1-cycle-latency memory, and returns it as a 4-beat 32-bit R burst.
module read_channels_slv #(
  parameter int QDEPTH_LOG2 = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arvalid,
  output logic         arready,
  input  logic [3:0]   arid,
  input  logic [31:0]  araddr,
  output logic         rvalid,
  input  logic         rready,
  output logic [3:0]   rid,
  output logic [31:0]  rdata,
  output logic         rlast,
  output logic         mem_rd,
  output logic [31:0]  mem_addr,
  input  logic [127:0] mem_rdata,
  output logic         rd_busy
);

  localparam int QDEPTH = 1 << QDEPTH_LOG2;
  localparam logic [QDEPTH_LOG2:0]   CNT_FULL = (QDEPTH_LOG2+1)'(QDEPTH);
  localparam logic [QDEPTH_LOG2:0]   CNT_ONE  = (QDEPTH_LOG2+1)'(1);
  localparam logic [QDEPTH_LOG2-1:0] PTR_ONE  = QDEPTH_LOG2'(1);

  typedef struct packed {
    logic [3:0]  id;
    logic [27:0] line;
  } req_t;

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  req_t [QDEPTH-1:0]      q_mem_q, q_mem_d;
  logic [QDEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QDEPTH_LOG2:0]   count_q, count_d;
  state_t                 state_q, state_d;
  logic [1:0]             beat_q, beat_d;
  logic [3:0]             cur_id_q, cur_id_d;
  logic [127:0]           line_q, line_d;

  logic full, empty, push, pop;
  req_t head;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign head    = q_mem_q[rd_ptr_q];
  // arready ignores a same-cycle pop: no push-through when full
  assign arready = !full;
  assign push    = arvalid && !full;
  assign pop     = (state_q == IDLE) && !empty;

  assign mem_addr = empty ? 32'h0 : {head.line, 4'h0};
  assign rd_busy  = !empty || (state_q != IDLE);

  always_comb begin
    q_mem_d  = q_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      q_mem_d[wr_ptr_q] = '{id: arid, line: araddr[31:4]};
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    cur_id_d = cur_id_q;
    line_d   = line_q;
    mem_rd   = 1'b0;
    rvalid   = 1'b0;
    rid      = 4'h0;
    rdata    = 32'h0;
    rlast    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          mem_rd   = 1'b1;
          cur_id_d = head.id;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        line_d  = mem_rdata;
        beat_d  = 2'd0;
        state_d = SEND;
      end
      SEND: begin
        rvalid = 1'b1;
        rid    = cur_id_q;
        rdata  = line_q[{beat_q, 5'b0} +: 32];
        rlast  = (beat_q == 2'd3);
        if (rready) begin
          // beat 3 + 1 wraps to 0 exactly as the burst leaves SEND
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3)
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_mem_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      beat_q   <= 2'd0;
      cur_id_q <= 4'h0;
      line_q   <= '0;
    end else begin
      q_mem_q  <= q_mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      beat_q   <= beat_d;
      cur_id_q <= cur_id_d;
      line_q   <= line_d;
    end
  end

endmodule
